mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Sequences one load or store at a time from the MEM stage onto the core's 64-bit data-memory request/response bus. It does four things:
- Replicates store data across byte lanes and generates the byte write mask.
- Checks natural alignment.
- Holds the bus handshake and times out a missing response.
- Extracts and sign/zero-extends load data.
It sits between the MEM pipeline stage and the data-memory port, and the stage stalls on it.

Parameters:
TIMEOUT_CYCLES, 1023, cycles spent in WAIT with no mem_resp_valid before the access is aborted with an error.
CNT_WIDTH, 10, width of the timeout counter. It must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  core clock; all state updates on the rising edge
rstn  in  1  asynchronous, active-low reset
req_valid  in  1  MEM stage presents an access
req_ready  out  1  controller accepts the access; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_addr  in  64  byte address
req_wdata  in  64  store data, right-aligned
req_op  in  3  CorePack::mem_op_enum (MEM_NO, MEM_B, MEM_H, MEM_W, MEM_D, MEM_UB, MEM_UH, MEM_UW)
resp_valid  out  1  one-cycle pulse: access finished
resp_rdata  out  64  extended load data; 0 for stores, MEM_NO and errors
resp_err  out  1  valid with resp_valid: misaligned access or timeout
busy  out  1  state != IDLE; drives the MEM-stage stall
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts the request
mem_we  out  1  bus write enable
mem_addr  out  64  req_addr with bits [2:0] forced to 0
mem_wdata  out  64  lane-replicated store data
mem_wmask  out  8  byte write enables; 0 for loads
mem_resp_valid  in  1  read data valid, or write acknowledge
mem_resp_rdata  in  64  read data, full doubleword

Behaviour:
States: IDLE, ISSUE, WAIT, RESP. The state register and all registered outputs are reset asynchronously on rstn low.

Reset values:
- State is IDLE, and the captured request and counter are 0.
- resp_valid, resp_err, resp_rdata, busy, mem_req_valid, mem_we, mem_addr, mem_wdata and mem_wmask are all 0.
- req_ready is 1, because it is decoded directly from IDLE.

Accept (IDLE, req_valid=1):
- Capture we, addr, wdata and op.
- Check alignment: H/UH need addr[0]=0; W/UW need addr[1:0]=0; D needs addr[2:0]=0. B/UB never misalign.
- Next state:
  - Misaligned: RESP with err=1.
  - op=MEM_NO: RESP with err=0 and rdata=0.
  - Otherwise: ISSUE.
- No bus traffic occurs for misaligned or MEM_NO accesses.

ISSUE:
- mem_req_valid=1. mem_we, mem_addr, mem_wdata and mem_wmask are driven from the captured request and held stable until mem_req_ready=1.
- On the handshake cycle, go to WAIT and clear the counter.
- ISSUE has no timeout.

Store data replication:
- B/UB: byte 0 copied 8 times.
- H/UH: halfword copied 4 times.
- W/UW: word copied twice.
- D: data unchanged.

Write mask, with off=addr[2:0]:
- B: 8'h01<<off.
- H: 8'h03<<off.
- W: 8'h0F<<off.
- D: 8'hFF.
- Loads: mem_wmask=0.

WAIT:
- mem_req_valid=0.
- On mem_resp_valid=1: go to RESP with err=0 and latch the extracted data.
- Otherwise the counter increments. When the counter equals TIMEOUT_CYCLES-1 and no response has arrived, go to RESP with err=1 and rdata=0.
- A response arriving on that same cycle wins.
- mem_resp_valid is ignored in IDLE, ISSUE and RESP. It is never accepted in the same cycle as the request handshake.

Load extraction, from byte lane off:
- B: sign-extend byte off.
- UB: zero-extend byte off.
- H/UH: sign/zero-extend halfword at byte off.
- W/UW: sign/zero-extend word at byte off.
- D: full 64 bits.
- Stores return rdata=0.

RESP:
- resp_valid=1 for exactly one cycle, with resp_rdata and resp_err stable.
- req_ready=0. Next state is IDLE.
- Minimum latency from accept to resp_valid:
  - 1 cycle for MEM_NO or error.
  - 3 cycles for a bus access with mem_req_ready=1 and a response on the first WAIT cycle.

Reset during an access:
- Any in-flight access is dropped immediately, with no resp_valid.
- A late mem_resp_valid after reset is ignored.

Test Plan:
1. Store SB, addr=0x1003, wdata=0x..AB, mem_req_ready=1, ack on the next cycle. Required: mem_addr=0x1000, mem_wdata=0xABABABABABABABAB, mem_wmask=8'h08, mem_we=1; then resp_valid=1, err=0, rdata=0.
2. Load LH, addr=0x2006, mem_resp_rdata=0x8001_0000_0000_0000. Required: mem_wmask=0, resp_rdata=0xFFFFFFFFFFFF8001. The same access as LHU gives 0x0000000000008001.
3. LW at addr=0x3002. Required: no mem_req_valid; resp_valid one cycle after accept, resp_err=1, rdata=0. MEM_NO at any address: resp_err=0, rdata=0, no bus request.
4. SD with mem_req_ready held low for 5 cycles. Required: mem_req_valid, mem_addr, mem_wdata and mem_wmask stable for all 5 cycles; wmask=8'hFF; transition to WAIT only on the ready cycle.
5. Load with no mem_resp_valid, TIMEOUT_CYCLES=4. Required: resp_valid with err=1 after 4 WAIT cycles. A stray mem_resp_valid arriving afterwards in IDLE has no effect.
6. rstn pulled low in WAIT, then mem_resp_valid arrives after release. Required: all outputs return to their reset values immediately, req_ready=1, no resp_valid; the next request proceeds normally.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: MEM-stage request/response and data-memory bus signals
interface mem_access_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [2:0]  req_op;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        busy;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_rdata;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_op,
      input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err, busy,
      output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_op,
      output mem_req_ready, mem_resp_valid, mem_resp_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, busy,
      input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one load/store at a time onto the 64-bit data-memory bus
module mem_access_ctrl #(
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int CNT_WIDTH      = 10
) (
   input logic              clk,
   input logic              rstn,
   mem_access_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [2:0] MEM_NO = 3'd0, MEM_B = 3'd1, MEM_H = 3'd2, MEM_W = 3'd3;
   localparam logic [2:0] MEM_D = 3'd4, MEM_UB = 3'd5, MEM_UH = 3'd6, MEM_UW = 3'd7;

   state_t               state, next_state;
   logic                 we_q, err_q;
   logic [63:0]          addr_q, wdata_q, rdata_q;
   logic [2:0]           op_q;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 misal, timeout, issue;
   logic [2:0]           align_mask, off;
   logic [63:0]          lane, ext, rep;
   logic [7:0]           mask;

   // natural-alignment check on the request being offered
   always_comb begin
      align_mask = (bus.req_op == MEM_H || bus.req_op == MEM_UH) ? 3'b001 :
                   (bus.req_op == MEM_W || bus.req_op == MEM_UW) ? 3'b011 :
                   (bus.req_op == MEM_D) ? 3'b111 : 3'b000;
      misal = |(bus.req_addr[2:0] & align_mask);
   end

   // store lane replication, byte write mask and load lane extraction
   always_comb begin
      off  = addr_q[2:0];
      rep  = (op_q == MEM_B || op_q == MEM_UB) ? {8{wdata_q[7:0]}} :
             (op_q == MEM_H || op_q == MEM_UH) ? {4{wdata_q[15:0]}} :
             (op_q == MEM_W || op_q == MEM_UW) ? {2{wdata_q[31:0]}} : wdata_q;
      mask = (op_q == MEM_B || op_q == MEM_UB) ? 8'h01 << off :
             (op_q == MEM_H || op_q == MEM_UH) ? 8'h03 << off :
             (op_q == MEM_W || op_q == MEM_UW) ? 8'h0F << off : 8'hFF;
      lane = bus.mem_resp_rdata >> {off, 3'b000};
      ext  = (op_q == MEM_B)  ? {{56{lane[7]}}, lane[7:0]} :
             (op_q == MEM_UB) ? {56'd0, lane[7:0]} :
             (op_q == MEM_H)  ? {{48{lane[15]}}, lane[15:0]} :
             (op_q == MEM_UH) ? {48'd0, lane[15:0]} :
             (op_q == MEM_W)  ? {{32{lane[31]}}, lane[31:0]} :
             (op_q == MEM_UW) ? {32'd0, lane[31:0]} : lane;
   end

   // next-state decode; a response in the final WAIT cycle beats the timeout
   always_comb begin
      timeout    = cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1);
      next_state = state;
      case (state)
         IDLE:    if (bus.req_valid) next_state = (misal || bus.req_op == MEM_NO) ? RESP : ISSUE;
         ISSUE:   if (bus.mem_req_ready) next_state = WAIT;
         WAIT:    if (bus.mem_resp_valid || timeout) next_state = RESP;
         default: next_state = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) state <= IDLE;
      else state <= next_state;

   // captured request, WAIT-cycle counter and latched response
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         op_q    <= MEM_NO;
         err_q   <= 1'b0;
         rdata_q <= '0;
         cnt     <= '0;
      end else begin
         if (state == IDLE && bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            op_q    <= bus.req_op;
            err_q   <= misal;
            rdata_q <= '0;
            cnt     <= '0;
         end
         if (state == ISSUE && bus.mem_req_ready) cnt <= '0;
         if (state == WAIT) begin
            if (bus.mem_resp_valid) begin
               err_q   <= 1'b0;
               rdata_q <= we_q ? '0 : ext;
            end else if (timeout) begin
               err_q   <= 1'b1;
               rdata_q <= '0;
            end else cnt <= cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign issue             = state == ISSUE;
   assign bus.req_ready     = state == IDLE;
   assign bus.busy          = state != IDLE;
   assign bus.resp_valid    = state == RESP;
   assign bus.resp_err      = bus.resp_valid & err_q;
   assign bus.resp_rdata    = bus.resp_valid ? rdata_q : '0;
   assign bus.mem_req_valid = issue;
   assign bus.mem_we        = issue & we_q;
   assign bus.mem_addr      = issue ? {addr_q[63:3], 3'b000} : '0;
   assign bus.mem_wdata     = issue ? rep : '0;
   assign bus.mem_wmask     = (issue && we_q) ? mask : '0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for the load/store bus sequencer
module tb_mem_access_ctrl;
   localparam logic [2:0] MEM_NO = 3'd0, MEM_B = 3'd1, MEM_H = 3'd2, MEM_W = 3'd3;
   localparam logic [2:0] MEM_D = 3'd4, MEM_UB = 3'd5, MEM_UH = 3'd6, MEM_UW = 3'd7;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [64:0] sb_q[$];
   logic prev_resp = 1'b0;

   mem_access_ctrl_if bus();

   mem_access_ctrl #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(10)) dut (
      .clk(clk),
      .rstn(rstn),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // response scoreboard: every resp_valid pops one expected {err, rdata}
   always @(negedge clk) begin
      if (rstn && bus.resp_valid) begin
         logic [64:0] exp;
         checks++;
         if (prev_resp) begin
            errors++;
            $display("FAIL resp_pulse: resp_valid high two cycles in a row");
         end else if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp: got err=%0b rdata=%h, none expected", bus.resp_err, bus.resp_rdata);
         end else begin
            exp = sb_q.pop_front();
            if ({bus.resp_err, bus.resp_rdata} !== exp)
               begin
                  errors++;
                  $display("FAIL resp: got err=%0b rdata=%h, expected err=%0b rdata=%h",
                           bus.resp_err, bus.resp_rdata, exp[64], exp[63:0]);
               end
         end
      end
      prev_resp = rstn && bus.resp_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [2:0] op, input logic [63:0] exp_rdata, input logic exp_err);
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_op    = op;
      sb_q.push_back({exp_err, exp_rdata});
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic ack_next;
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b1;
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b0;
   endtask

   task automatic drain;
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d responses still outstanding, expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_reset;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      bus.req_op = MEM_NO; bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = '0;
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.req_ready, bus.busy, bus.resp_valid, bus.resp_err, bus.mem_req_valid, bus.mem_we} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b, expected 100000",
                  {bus.req_ready, bus.busy, bus.resp_valid, bus.resp_err, bus.mem_req_valid, bus.mem_we});
      end
      checks++;
      if ({bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.resp_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_data: addr=%h wdata=%h wmask=%h rdata=%h, expected all 0",
                  bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.resp_rdata);
      end
      rstn = 1'b1;
   endtask

   task automatic test_stores;
      logic [63:0] addr [4] = '{64'h1003, 64'h1006, 64'h1004, 64'h1000};
      logic [2:0]  op   [4] = '{MEM_B, MEM_H, MEM_W, MEM_D};
      logic [63:0] wd   [4] = '{64'hABABABABABABABAB, 64'hDEABDEABDEABDEAB,
                                64'h9ABCDEAB9ABCDEAB, 64'h123456789ABCDEAB};
      logic [7:0]  wm   [4] = '{8'h08, 8'hC0, 8'hF0, 8'hFF};
      bus.mem_req_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(1'b1, addr[i], 64'h123456789ABCDEAB, op[i], 64'd0, 1'b0);
         checks++;
         if ({bus.mem_req_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !==
             {2'b11, addr[i] & ~64'h7, wd[i], wm[i]}) begin
            errors++;
            $display("FAIL store_%0d: v=%0b we=%0b addr=%h wdata=%h wmask=%h, expected v=1 we=1 addr=%h wdata=%h wmask=%h",
                     i, bus.mem_req_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask,
                     addr[i] & ~64'h7, wd[i], wm[i]);
         end
         ack_next();
         drain();
      end
   endtask

   task automatic test_loads;
      logic [63:0] addr [7] = '{64'h2006, 64'h2006, 64'h2004, 64'h2007, 64'h2007, 64'h2000, 64'h2004};
      logic [2:0]  op   [7] = '{MEM_H, MEM_UH, MEM_W, MEM_UB, MEM_B, MEM_D, MEM_UW};
      logic [63:0] exp  [7] = '{64'hFFFFFFFFFFFF8001, 64'h0000000000008001, 64'hFFFFFFFF80010000,
                                64'h0000000000000080, 64'hFFFFFFFFFFFFFF80, 64'h8001000000000000,
                                64'h0000000080010000};
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_rdata = 64'h8001000000000000;
      for (int i = 0; i < 7; i++) begin
         send(1'b0, addr[i], 64'hFFFFFFFFFFFFFFFF, op[i], exp[i], 1'b0);
         checks++;
         if ({bus.mem_req_valid, bus.mem_we, bus.mem_wmask, bus.mem_addr} !== {2'b10, 8'h00, 64'h2000}) begin
            errors++;
            $display("FAIL load_bus_%0d: v=%0b we=%0b wmask=%h addr=%h, expected v=1 we=0 wmask=00 addr=2000",
                     i, bus.mem_req_valid, bus.mem_we, bus.mem_wmask, bus.mem_addr);
         end
         ack_next();
         drain();
      end
   endtask

   task automatic test_no_bus;
      logic [63:0] addr [6] = '{64'h3002, 64'h3001, 64'h3004, 64'h3006, 64'h3007, 64'h3005};
      logic [2:0]  op   [6] = '{MEM_W, MEM_H, MEM_D, MEM_UW, MEM_NO, MEM_NO};
      logic        we   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic        err  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_rdata = 64'hFFFFFFFFFFFFFFFF;
      for (int i = 0; i < 6; i++) begin
         send(we[i], addr[i], 64'h5555, op[i], 64'd0, err[i]);
         checks++;
         if ({bus.mem_req_valid, bus.resp_valid, bus.req_ready} !== 3'b010) begin
            errors++;
            $display("FAIL no_bus_%0d: mem_req_valid=%0b resp_valid=%0b req_ready=%0b, expected 0 1 0",
                     i, bus.mem_req_valid, bus.resp_valid, bus.req_ready);
         end
         drain();
      end
   endtask

   task automatic test_stall;
      bus.mem_req_ready = 1'b0;
      send(1'b1, 64'h4008, 64'hCAFEF00DDEADBEEF, MEM_D, 64'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({bus.mem_req_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !==
             {1'b1, 64'h4008, 64'hCAFEF00DDEADBEEF, 8'hFF}) begin
            errors++;
            $display("FAIL stall_%0d: v=%0b addr=%h wdata=%h wmask=%h, expected v=1 addr=4008 wdata=cafef00ddeadbeef wmask=ff",
                     i, bus.mem_req_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
         end
         @(posedge clk); #1;
      end
      bus.mem_req_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({bus.mem_req_valid, bus.busy, bus.resp_valid} !== 3'b010) begin
         errors++;
         $display("FAIL stall_wait: v=%0b busy=%0b resp_valid=%0b, expected 0 1 0",
                  bus.mem_req_valid, bus.busy, bus.resp_valid);
      end
      bus.mem_resp_valid = 1'b1;
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b0;
      drain();
   endtask

   task automatic test_timeout;
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'b0;
      send(1'b0, 64'h5000, 64'd0, MEM_D, 64'd0, 1'b1);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({bus.busy, bus.resp_valid, bus.mem_req_valid} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_wait_%0d: busy=%0b resp_valid=%0b v=%0b, expected 1 0 0",
                     i, bus.busy, bus.resp_valid, bus.mem_req_valid);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (bus.resp_valid !== 1'b1) begin
         errors++;
         $display("FAIL timeout_resp: resp_valid=%0b, expected 1", bus.resp_valid);
      end
      drain();
      bus.mem_resp_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.mem_resp_valid = 1'b0;
      checks++;
      if ({bus.busy, bus.req_ready} !== 2'b01) begin
         errors++;
         $display("FAIL stray_idle: busy=%0b req_ready=%0b, expected 0 1", bus.busy, bus.req_ready);
      end
      bus.mem_resp_rdata = 64'h0123456789ABCDEF;
      send(1'b0, 64'h5008, 64'd0, MEM_D, 64'h0123456789ABCDEF, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      bus.mem_resp_valid = 1'b1;
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b0;
      checks++;
      if (bus.resp_valid !== 1'b1) begin
         errors++;
         $display("FAIL timeout_race: resp_valid=%0b, expected 1", bus.resp_valid);
      end
      drain();
   endtask

   task automatic test_reset_mid;
      bus.mem_req_ready = 1'b1;
      send(1'b0, 64'h6000, 64'd0, MEM_D, 64'd0, 1'b0);
      @(posedge clk); #1;
      rstn = 1'b0;
      sb_q.delete();
      #1;
      checks++;
      if ({bus.req_ready, bus.busy, bus.resp_valid, bus.mem_req_valid, bus.mem_wmask, bus.mem_addr} !== {4'b1000, 8'h00, 64'h0}) begin
         errors++;
         $display("FAIL reset_mid: ready=%0b busy=%0b resp_valid=%0b v=%0b wmask=%h addr=%h, expected 1 0 0 0 00 0",
                  bus.req_ready, bus.busy, bus.resp_valid, bus.mem_req_valid, bus.mem_wmask, bus.mem_addr);
      end
      @(posedge clk); #1;
      rstn = 1'b1;
      bus.mem_resp_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.mem_resp_valid = 1'b0;
      checks++;
      if ({bus.busy, bus.req_ready, bus.resp_valid} !== 3'b010) begin
         errors++;
         $display("FAIL reset_late_resp: busy=%0b ready=%0b resp_valid=%0b, expected 0 1 0",
                  bus.busy, bus.req_ready, bus.resp_valid);
      end
      bus.mem_resp_rdata = 64'h7FFFFFFF12345678;
      send(1'b0, 64'h6004, 64'd0, MEM_W, 64'h000000007FFFFFFF, 1'b0);
      ack_next();
      drain();
   endtask

   initial begin
      test_reset();
      test_stores();
      test_loads();
      test_no_bus();
      test_stall();
      test_timeout();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
